// File: rtl/traffic_light_nway.sv
// N-way intersection controller: round-robin green among latched car requests, timed yellow / all-red, seconds countdown on two 7-seg digits.
// Latency: SW registered once, so a request reaches pending two edges after it is applied; LED changes in the same edge as the state.
// Backpressure: none; requests are latched in pending until served. Optional pedestrian phase enabled by macro TRAFFIC_PED_EN.
module traffic_light_nway #(
    parameter int N_DIR      = 4,
    parameter int CNT_MAX    = 50000000,
    parameter int GREEN_SEC  = 30,
    parameter int YELLOW_SEC = 3,
    parameter int ALLRED_SEC = 1,
    parameter int WALK_SEC   = 10
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    input  logic [N_DIR-1:0]     SW,
`ifdef TRAFFIC_PED_EN
    input  logic                 PED_BTN,
    output logic                 LED_WALK,
`endif
    output logic [3*N_DIR-1:0]   LED,
    output logic [6:0]           HEX0,
    output logic [6:0]           HEX1
);

    localparam int IDX_W = $clog2(N_DIR);
    localparam int PRE_W = $clog2(CNT_MAX);

    localparam logic [1:0] S_GREEN  = 2'd0;
    localparam logic [1:0] S_YELLOW = 2'd1;
    localparam logic [1:0] S_ALLRED = 2'd2;
`ifdef TRAFFIC_PED_EN
    localparam logic [1:0] S_WALK   = 2'd3;
    localparam logic [6:0] L_WALK   = 7'(WALK_SEC);
`endif

    localparam logic [6:0] L_GREEN  = 7'(GREEN_SEC);
    localparam logic [6:0] L_YELLOW = 7'(YELLOW_SEC);
    localparam logic [6:0] L_ALLRED = 7'(ALLRED_SEC);

    // Parameter sanity: the two-digit display caps every phase at 99 s.
    generate
        if (N_DIR < 2 || N_DIR > 8 || CNT_MAX < 2 ||
            GREEN_SEC < 1 || GREEN_SEC > 99 || YELLOW_SEC < 1 || YELLOW_SEC > 99 ||
            ALLRED_SEC < 1 || ALLRED_SEC > 99 || WALK_SEC < 1 || WALK_SEC > 99) begin : g_param_check
            $error("traffic_light_nway: parameter out of range");
        end
    endgenerate

    // Approach index cur+off wrapped modulo N_DIR.
    function automatic logic [IDX_W-1:0] wrap_idx(input logic [IDX_W-1:0] base, input int off);
        int s;
        s = (int'(base) + off) % N_DIR;
        return IDX_W'(s);
    endfunction

    // Lamp pattern for a state and current approach: {red, yellow, green} per approach.
    function automatic logic [3*N_DIR-1:0] lamps(input logic [1:0] st, input logic [IDX_W-1:0] cur);
        logic [3*N_DIR-1:0] v;
        v = '0;
        for (int d = 0; d < N_DIR; d++) begin
            if (IDX_W'(d) == cur && st == S_GREEN)
                v[3*d +: 3] = 3'b001;
            else if (IDX_W'(d) == cur && st == S_YELLOW)
                v[3*d +: 3] = 3'b010;
            else
                v[3*d +: 3] = 3'b100;
        end
        return v;
    endfunction

    // Active-low gfedcba decode of one decimal digit.
    function automatic logic [6:0] seg7(input logic [3:0] dig);
        logic [6:0] s;
        case (dig)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    logic [N_DIR-1:0]   r_sw;
    logic [1:0]         r_state;
    logic [IDX_W-1:0]   r_cur;
    logic [IDX_W-1:0]   r_nxt;
    logic [N_DIR-1:0]   r_pending;
    logic [PRE_W-1:0]   r_presc;
    logic [6:0]         r_sec;
    logic [3*N_DIR-1:0] r_led;

    logic               w_tick;
    logic               w_sec_zero;
    logic               w_any_req;
    logic [IDX_W-1:0]   w_pick;
    logic [1:0]         w_state_nxt;
    logic               w_enter;
    logic [6:0]         w_dur;
    logic               w_to_green;
    logic [IDX_W-1:0]   w_cur_nxt;
    logic [N_DIR-1:0]   w_cur_mask;
    logic [N_DIR-1:0]   w_pending_nxt;

`ifdef TRAFFIC_PED_EN
    logic               r_ped_btn;
    logic               r_ped_pending;
    logic               r_walk_done;
    logic               r_led_walk;
`endif

    assign w_tick     = (r_presc == PRE_W'(CNT_MAX - 1));
    assign w_sec_zero = (r_sec == 7'd0);
`ifdef TRAFFIC_PED_EN
    assign w_any_req  = (|r_pending) | r_ped_pending;
`else
    assign w_any_req  = |r_pending;
`endif

    // Round-robin search: nearest pending approach after cur; cur itself if none.
    always_comb begin
        w_pick = r_cur;
        for (int k = N_DIR - 1; k >= 1; k--) begin
            if (r_pending[wrap_idx(r_cur, k)])
                w_pick = wrap_idx(r_cur, k);
        end
    end

    // Phase sequencing: every transition is a phase entry that reloads the timer.
    always_comb begin
        w_state_nxt = r_state;
        w_enter     = 1'b0;
        w_dur       = L_GREEN;
        case (r_state)
            S_GREEN: begin
                if (w_sec_zero && w_any_req) begin
                    w_state_nxt = S_YELLOW;
                    w_enter     = 1'b1;
                    w_dur       = L_YELLOW;
                end
            end
            S_YELLOW: begin
                if (w_sec_zero) begin
                    w_state_nxt = S_ALLRED;
                    w_enter     = 1'b1;
                    w_dur       = L_ALLRED;
                end
            end
            S_ALLRED: begin
                if (w_sec_zero) begin
                    w_enter     = 1'b1;
`ifdef TRAFFIC_PED_EN
                    // Walk only from the first all-red; the one after walk goes to green.
                    if (r_ped_pending && !r_walk_done) begin
                        w_state_nxt = S_WALK;
                        w_dur       = L_WALK;
                    end else begin
                        w_state_nxt = S_GREEN;
                        w_dur       = L_GREEN;
                    end
`else
                    w_state_nxt = S_GREEN;
                    w_dur       = L_GREEN;
`endif
                end
            end
`ifdef TRAFFIC_PED_EN
            S_WALK: begin
                if (w_sec_zero) begin
                    w_state_nxt = S_ALLRED;
                    w_enter     = 1'b1;
                    w_dur       = L_ALLRED;
                end
            end
`endif
            default: begin
                w_state_nxt = S_GREEN;
                w_enter     = 1'b1;
                w_dur       = L_GREEN;
            end
        endcase
    end

    assign w_to_green = w_enter && (w_state_nxt == S_GREEN);
    assign w_cur_nxt  = w_to_green ? r_nxt : r_cur;
    assign w_cur_mask = N_DIR'(1) << r_cur;

    // Latch requests from other approaches; the approach entering green is cleared.
    always_comb begin
        w_pending_nxt = r_pending | (r_sw & ~w_cur_mask);
        if (w_to_green)
            w_pending_nxt[r_nxt] = 1'b0;
    end

    // Main state, timer and lamp registers.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_sw      <= '0;
            r_state   <= S_GREEN;
            r_cur     <= '0;
            r_nxt     <= '0;
            r_pending <= '0;
            r_presc   <= '0;
            r_sec     <= L_GREEN;
            r_led     <= lamps(S_GREEN, '0);
        end else begin
            r_sw      <= SW;
            r_state   <= w_state_nxt;
            r_cur     <= w_cur_nxt;
            r_pending <= w_pending_nxt;
            r_led     <= lamps(w_state_nxt, w_cur_nxt);
            if (r_state == S_GREEN && w_enter)
                r_nxt <= w_pick;
            if (w_enter || w_tick)
                r_presc <= '0;
            else
                r_presc <= r_presc + PRE_W'(1);
            if (w_enter)
                r_sec <= w_dur;
            else if (w_tick && !w_sec_zero)
                r_sec <= r_sec - 7'd1;
        end
    end

`ifdef TRAFFIC_PED_EN
    // Pedestrian request latch and walk lamp.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            r_ped_btn     <= 1'b0;
            r_ped_pending <= 1'b0;
            r_walk_done   <= 1'b0;
            r_led_walk    <= 1'b0;
        end else begin
            r_ped_btn  <= PED_BTN;
            r_led_walk <= (w_state_nxt == S_WALK);
            if (w_enter && w_state_nxt == S_WALK)
                r_ped_pending <= 1'b0;
            else if (r_ped_btn)
                r_ped_pending <= 1'b1;
            if (w_enter && w_state_nxt == S_WALK)
                r_walk_done <= 1'b1;
            else if (w_to_green)
                r_walk_done <= 1'b0;
        end
    end

    assign LED_WALK = r_led_walk;
`endif

    assign LED  = r_led;
    assign HEX0 = seg7(4'(r_sec % 7'd10));
    assign HEX1 = (r_sec < 7'd10) ? 7'h7F : seg7(4'(r_sec / 7'd10));

endmodule

// File: tb/tb_traffic_light_nway.sv
// Directed bench for traffic_light_nway with a 5-clock second and 4 approaches.
// Edge 0 is the last clock edge with RESET high; cyc counts edges after it.
// Expected lamp and digit patterns are hand-written constants.
module tb_traffic_light_nway;

    localparam int N_DIR = 4;

    localparam logic [11:0] G0 = 12'b100_100_100_001;
    localparam logic [11:0] Y0 = 12'b100_100_100_010;
    localparam logic [11:0] G1 = 12'b100_100_001_100;
    localparam logic [11:0] Y1 = 12'b100_100_010_100;
    localparam logic [11:0] G2 = 12'b100_001_100_100;
    localparam logic [11:0] G3 = 12'b001_100_100_100;
    localparam logic [11:0] AR = 12'b100_100_100_100;

    localparam logic [6:0] SEG0  = 7'b1000000;
    localparam logic [6:0] SEG1  = 7'b1111001;
    localparam logic [6:0] SEG2  = 7'b0100100;
    localparam logic [6:0] SEG3  = 7'b0110000;
    localparam logic [6:0] SEG4  = 7'b0011001;
    localparam logic [6:0] BLANK = 7'h7F;

    logic              clk = 1'b0;
    logic              rst;
    logic [N_DIR-1:0]  sw;
    logic [3*N_DIR-1:0] led;
    logic [6:0]        hex0;
    logic [6:0]        hex1;
`ifdef TRAFFIC_PED_EN
    logic              ped_btn;
    logic              led_walk;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    traffic_light_nway #(
        .N_DIR      (N_DIR),
        .CNT_MAX    (5),
        .GREEN_SEC  (4),
        .YELLOW_SEC (2),
        .ALLRED_SEC (1),
        .WALK_SEC   (3)
    ) dut (
        .CLOCK_50 (clk),
        .RESET    (rst),
        .SW       (sw),
`ifdef TRAFFIC_PED_EN
        .PED_BTN  (ped_btn),
        .LED_WALK (led_walk),
`endif
        .LED      (led),
        .HEX0     (hex0),
        .HEX1     (hex1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic go_to(input int t);
        while (cyc < t) step(1);
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    // Wait through the next all-red and return once a non-all-red pattern appears.
    task automatic next_after_allred(input int budget);
        int k;
        k = 0;
        while (led != AR && k < budget) begin step(1); k++; end
        while (led == AR && k < budget) begin step(1); k++; end
    endtask

    initial begin
        rst = 1'b1;
        sw  = '0;
`ifdef TRAFFIC_PED_EN
        ped_btn = 1'b0;
`endif

        // Reset state and countdown with no requests.
        do_reset(2);
        check("reset_led", led, G0);
        check("reset_hex0", hex0, SEG4);
        check("reset_hex1", hex1, BLANK);
`ifdef TRAFFIC_PED_EN
        check("reset_walk", led_walk, 1'b0);
`endif
        go_to(5);
        check("cnt_hex0_3", hex0, SEG3);
        go_to(19);
        check("cnt_hex0_1", hex0, SEG1);
        go_to(20);
        check("cnt_hex0_0", hex0, SEG0);
        go_to(100);
        check("idle_led", led, G0);
        check("idle_hex0", hex0, SEG0);

        // Single SW[2] pulse applied before edge 3.
        do_reset(2);
        step(2);
        sw = 4'b0100;
        step(1);
        sw = 4'b0000;
        go_to(20);
        check("pulse_g_hold", led, G0);
        go_to(21);
        check("pulse_yellow", led, Y0);
        check("pulse_y_hex0", hex0, SEG2);
        go_to(31);
        check("pulse_y_hold", led, Y0);
        go_to(32);
        check("pulse_allred", led, AR);
        go_to(37);
        check("pulse_ar_hold", led, AR);
        go_to(38);
        check("pulse_green2", led, G2);
        check("pulse_g2_hex0", hex0, SEG4);

        // Round-robin wrap from approach 2 with 0, 1, 3 requesting.
        sw = 4'b1011;
        next_after_allred(200);
        check("rr_first", led, G3);
        next_after_allred(200);
        check("rr_second", led, G0);
        next_after_allred(200);
        check("rr_third", led, G1);
        sw = 4'b0000;

        // Reset in the middle of yellow while approach 3 is still pending.
        begin
            int k;
            k = 0;
            while (led != Y1 && k < 200) begin step(1); k++; end
        end
        check("pre_rst_yellow", led, Y1);
        step(3);
        do_reset(1);
        check("midrst_led", led, G0);
        check("midrst_hex0", hex0, SEG4);
        check("midrst_hex1", hex1, BLANK);
        go_to(60);
        check("midrst_no_serve", led, G0);
        check("midrst_hex0_0", hex0, SEG0);

`ifdef TRAFFIC_PED_EN
        // Pedestrian walk from approach 0 green, then back to approach 0.
        do_reset(2);
        step(2);
        ped_btn = 1'b1;
        step(1);
        ped_btn = 1'b0;
        go_to(21);
        check("ped_yellow", led, Y0);
        go_to(37);
        check("ped_allred1", led, AR);
        check("ped_walk_off", led_walk, 1'b0);
        go_to(38);
        check("ped_walk_on", led_walk, 1'b1);
        check("ped_walk_led", led, AR);
        check("ped_walk_hex0", hex0, SEG3);
        go_to(53);
        check("ped_walk_hold", led_walk, 1'b1);
        go_to(54);
        check("ped_walk_end", led_walk, 1'b0);
        check("ped_allred2", led, AR);
        go_to(59);
        check("ped_ar2_hold", led, AR);
        go_to(60);
        check("ped_back_g0", led, G0);
        check("ped_back_hex0", hex0, SEG4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

endmodule
